// File: rtl/gol_gen_sequencer.sv
// gol_gen_sequencer
//   Generation sequencer for a Game of Life board. It holds the displayed
//   (front) board and a shadow (back) board. Each generation is computed one
//   cell per clock into the back board. The back board is then copied to the
//   front board in a single cycle, so readers never see a half-updated board.
//
// Ports
//   clk        system/pixel clock
//   rst_n      asynchronous active-low reset (front = SEED)
//   frame_tick one-cycle pulse per video frame
//   run        level; auto-advance every FRAMES_PER_GEN frame ticks
//   step       pulse; advance one generation (honoured only while run = 0)
//   clear      pulse; zero both boards and all counters
//   load       pulse; like clear, but the front board reloads SEED
//   rd_addr    display read address (row*W + col)
//   rd_cell    combinational front[rd_addr]
//   board      flat front board
//   busy       high while a generation is being scanned or committed
//   gen_done   one-cycle pulse in the cycle after a commit
//   gen_count  generations committed since reset/clear/load (wraps)
module gol_gen_sequencer #(
    parameter int BIT_WIDTH      = 3,
    parameter int BIT_HEIGHT     = 3,
    parameter int FRAMES_PER_GEN = 60,
    parameter logic [(1 << (BIT_WIDTH + BIT_HEIGHT)) - 1:0] SEED = 64'h0000_0000_1C00_0000
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      frame_tick,
    input  logic                                      run,
    input  logic                                      step,
    input  logic                                      clear,
    input  logic                                      load,
    input  logic [BIT_WIDTH + BIT_HEIGHT - 1:0]       rd_addr,
    output logic                                      rd_cell,
    output logic [(1 << (BIT_WIDTH + BIT_HEIGHT)) - 1:0] board,
    output logic                                      busy,
    output logic                                      gen_done,
    output logic [15:0]                               gen_count
);

    localparam int AW   = BIT_WIDTH + BIT_HEIGHT;
    localparam int SIZE = 1 << AW;
    localparam int W    = 1 << BIT_WIDTH;
    localparam int H    = 1 << BIT_HEIGHT;
    localparam int FC_W = $clog2(FRAMES_PER_GEN) + 1;

    typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     idx_q, idx_d;
    logic [FC_W-1:0]   frame_cnt_q, frame_cnt_d;
    logic [15:0]       gen_count_q, gen_count_d;
    logic [SIZE-1:0]   front_q, front_d;
    logic [SIZE-1:0]   back_q, back_d;
    logic              gen_done_q, gen_done_d;

    logic              trigger;
    logic [3:0]        n_cnt;
    logic              next_cell;

    // Live-neighbour count of the cell at idx_q. Off-board neighbours are
    // simply skipped, which makes the border behave as permanently dead.
    always_comb begin
        int r, c, rr, cc;
        logic [AW-1:0] nb;
        n_cnt = '0;
        nb    = '0;
        r     = int'(idx_q[AW-1:BIT_WIDTH]);
        c     = int'(idx_q[BIT_WIDTH-1:0]);
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                rr = r + dr;
                cc = c + dc;
                if (!(dr == 0 && dc == 0) && rr >= 0 && rr < H && cc >= 0 && cc < W) begin
                    nb    = AW'(rr * W + cc);
                    n_cnt = n_cnt + {3'b000, front_q[nb]};
                end
            end
        end
    end

    // Survive on 2 or 3, birth on exactly 3.
    assign next_cell = (n_cnt == 4'd3) || (front_q[idx_q] && n_cnt == 4'd2);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        frame_cnt_d = frame_cnt_q;
        gen_count_d = gen_count_q;
        front_d     = front_q;
        back_d      = back_q;
        gen_done_d  = 1'b0;
        trigger     = 1'b0;

        // The frame counter keeps running while busy; a trigger that lands
        // during a generation is lost, but the counter still wraps.
        if (frame_tick && run) begin
            if (frame_cnt_q == FC_W'(FRAMES_PER_GEN - 1)) begin
                frame_cnt_d = '0;
                trigger     = 1'b1;
            end else begin
                frame_cnt_d = frame_cnt_q + 1'b1;
            end
        end

        if (clear || load) begin
            front_d     = clear ? '0 : SEED;
            back_d      = '0;
            gen_count_d = '0;
            frame_cnt_d = '0;
            idx_d       = '0;
            state_d     = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (trigger || (step && !run)) begin
                        state_d = SCAN;
                    end
                end
                SCAN: begin
                    back_d[idx_q] = next_cell;
                    if (idx_q == AW'(SIZE - 1)) begin
                        idx_d   = '0;
                        state_d = COMMIT;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
                COMMIT: begin
                    front_d     = back_q;
                    gen_count_d = gen_count_q + 16'd1;
                    gen_done_d  = 1'b1;
                    state_d     = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            frame_cnt_q <= '0;
            gen_count_q <= '0;
            front_q     <= SEED;
            back_q      <= '0;
            gen_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            frame_cnt_q <= frame_cnt_d;
            gen_count_q <= gen_count_d;
            front_q     <= front_d;
            back_q      <= back_d;
            gen_done_q  <= gen_done_d;
        end
    end

    assign rd_cell   = front_q[rd_addr];
    assign board     = front_q;
    assign busy      = (state_q == SCAN) || (state_q == COMMIT);
    assign gen_done  = gen_done_q;
    assign gen_count = gen_count_q;

endmodule

// File: tb/tb_gol_gen_sequencer.sv
module tb_gol_gen_sequencer;

    localparam logic [63:0] SEED_H  = 64'h0000_0000_1C00_0000;
    localparam logic [63:0] VERT    = 64'h0000_0008_0808_0000;
    localparam logic [63:0] L_SEED  = 64'h0000_0000_0000_0301;
    localparam logic [63:0] BLOCK   = 64'h0000_0000_0000_0303;

    logic        clk, rst_n, frame_tick, run, step, clear, load;
    logic [5:0]  rd_addr;
    logic        rd_cell, busy, gen_done;
    logic [63:0] board;
    logic [15:0] gen_count;
    logic        l_rd_cell, l_busy, l_gen_done;
    logic [63:0] l_board;
    logic [15:0] l_gen_count;

    int vectors = 0;
    int miscompares = 0;
    int done_cnt = 0;

    gol_gen_sequencer #(.FRAMES_PER_GEN(3)) dut (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .run(run),
        .step(step), .clear(clear), .load(load), .rd_addr(rd_addr),
        .rd_cell(rd_cell), .board(board), .busy(busy),
        .gen_done(gen_done), .gen_count(gen_count)
    );

    gol_gen_sequencer #(.SEED(L_SEED)) dut_l (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .run(run),
        .step(step), .clear(clear), .load(load), .rd_addr(rd_addr),
        .rd_cell(l_rd_cell), .board(l_board), .busy(l_busy),
        .gen_done(l_gen_done), .gen_count(l_gen_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (gen_done === 1'b1) done_cnt++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_load();
        load = 1'b1; tick(); load = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        vectors++; if (board !== SEED_H) begin miscompares++; $display("FAIL reset_board got %h want %h", board, SEED_H); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
        vectors++; if (gen_count !== 16'd0) begin miscompares++; $display("FAIL reset_gen_count got %0d want 0", gen_count); end
        vectors++; if (gen_done !== 1'b0) begin miscompares++; $display("FAIL reset_gen_done got %b want 0", gen_done); end
        vectors++; if (l_board !== L_SEED) begin miscompares++; $display("FAIL reset_l_board got %h want %h", l_board, L_SEED); end
        @(negedge clk) rst_n = 1'b1;
        tick();
        repeat (3) tick();
        vectors++; if (board !== SEED_H || busy !== 1'b0) begin miscompares++; $display("FAIL idle_hold board %h busy %b want %h 0", board, busy, SEED_H); end
    endtask

    // Blinker step, then a second step issued in the first idle cycle.
    task automatic test_step();
        int bad;
        rd_addr = 6'd19;
        step = 1'b1; tick(); step = 1'b0;
        bad = 0;
        for (int k = 1; k <= 65; k++) begin
            if (busy !== 1'b1 || board !== SEED_H || gen_done !== 1'b0) bad++;
            tick();
        end
        vectors++; if (bad != 0) begin miscompares++; $display("FAIL busy_window bad_cycles %0d want 0", bad); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL step_busy_low got %b want 0", busy); end
        vectors++; if (board !== VERT) begin miscompares++; $display("FAIL step1_board got %h want %h", board, VERT); end
        vectors++; if (gen_done !== 1'b1) begin miscompares++; $display("FAIL step1_gen_done got %b want 1", gen_done); end
        vectors++; if (gen_count !== 16'd1) begin miscompares++; $display("FAIL step1_gen_count got %0d want 1", gen_count); end
        vectors++; if (rd_cell !== 1'b1) begin miscompares++; $display("FAIL step1_rd_cell got %b want 1", rd_cell); end
        step = 1'b1; tick(); step = 1'b0;
        vectors++; if (gen_done !== 1'b0 || busy !== 1'b1) begin miscompares++; $display("FAIL back_to_back_accept gen_done %b busy %b want 0 1", gen_done, busy); end
        repeat (65) tick();
        vectors++; if (board !== SEED_H) begin miscompares++; $display("FAIL step2_board got %h want %h", board, SEED_H); end
        vectors++; if (gen_count !== 16'd2) begin miscompares++; $display("FAIL step2_gen_count got %0d want 2", gen_count); end
        vectors++; if (rd_cell !== 1'b0) begin miscompares++; $display("FAIL step2_rd_cell got %b want 0", rd_cell); end
    endtask

    task automatic test_run();
        int d0;
        pulse_load();
        vectors++; if (gen_count !== 16'd0 || board !== SEED_H) begin miscompares++; $display("FAIL load_state count %0d board %h want 0 %h", gen_count, board, SEED_H); end
        run = 1'b1;
        step = 1'b1; tick(); step = 1'b0;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL step_ignored_in_run got %b want 0", busy); end
        d0 = done_cnt;
        for (int t = 1; t <= 7; t++) begin
            frame_tick = 1'b1; tick(); frame_tick = 1'b0;
            vectors++; if (busy !== ((t % 3) == 0)) begin miscompares++; $display("FAIL run_tick%0d_busy got %b want %b", t, busy, (t % 3) == 0); end
            repeat (80) tick();
        end
        vectors++; if (gen_count !== 16'd2 || board !== SEED_H) begin miscompares++; $display("FAIL run_result count %0d board %h want 2 %h", gen_count, board, SEED_H); end
        vectors++; if (done_cnt - d0 != 2) begin miscompares++; $display("FAIL run_done_pulses got %0d want 2", done_cnt - d0); end
        run = 1'b0;
        for (int t = 0; t < 4; t++) begin
            frame_tick = 1'b1; tick(); frame_tick = 1'b0;
            vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL stopped_tick%0d_busy got %b want 0", t, busy); end
            repeat (5) tick();
        end
        vectors++; if (gen_count !== 16'd2) begin miscompares++; $display("FAIL stopped_count got %0d want 2", gen_count); end
    endtask

    task automatic test_lshape();
        pulse_load();
        vectors++; if (l_board !== L_SEED) begin miscompares++; $display("FAIL l_load got %h want %h", l_board, L_SEED); end
        step = 1'b1; tick(); step = 1'b0;
        repeat (65) tick();
        vectors++; if (l_board !== BLOCK) begin miscompares++; $display("FAIL l_to_block got %h want %h", l_board, BLOCK); end
        vectors++; if (l_gen_done !== 1'b1 || l_gen_count !== 16'd1) begin miscompares++; $display("FAIL l_gen1 done %b count %0d want 1 1", l_gen_done, l_gen_count); end
        step = 1'b1; tick(); step = 1'b0;
        repeat (65) tick();
        vectors++; if (l_board !== BLOCK) begin miscompares++; $display("FAIL block_still got %h want %h", l_board, BLOCK); end
        vectors++; if (l_gen_count !== 16'd2) begin miscompares++; $display("FAIL block_count got %0d want 2", l_gen_count); end
    endtask

    task automatic test_clear();
        int d0;
        pulse_load();
        step = 1'b1; tick(); step = 1'b0;
        repeat (65) tick();
        vectors++; if (gen_count !== 16'd1) begin miscompares++; $display("FAIL pre_clear_count got %0d want 1", gen_count); end
        step = 1'b1; tick(); step = 1'b0;
        repeat (19) tick();
        d0 = done_cnt;
        clear = 1'b1; tick(); clear = 1'b0;
        vectors++; if (board !== 64'd0) begin miscompares++; $display("FAIL clear_board got %h want 0", board); end
        vectors++; if (gen_count !== 16'd0 || busy !== 1'b0) begin miscompares++; $display("FAIL clear_state count %0d busy %b want 0 0", gen_count, busy); end
        repeat (70) tick();
        vectors++; if (done_cnt != d0 || board !== 64'd0 || busy !== 1'b0) begin miscompares++; $display("FAIL clear_abort done %0d board %h busy %b want %0d 0 0", done_cnt, board, busy, d0); end
        step = 1'b1; tick(); step = 1'b0;
        repeat (65) tick();
        vectors++; if (board !== 64'd0 || gen_count !== 16'd1) begin miscompares++; $display("FAIL empty_gen board %h count %0d want 0 1", board, gen_count); end
        pulse_load();
        vectors++; if (board !== SEED_H) begin miscompares++; $display("FAIL reload got %h want %h", board, SEED_H); end
        clear = 1'b1; load = 1'b1; tick(); clear = 1'b0; load = 1'b0;
        vectors++; if (board !== 64'd0) begin miscompares++; $display("FAIL clear_over_load got %h want 0", board); end
    endtask

    task automatic test_reset_mid();
        pulse_load();
        step = 1'b1; tick(); step = 1'b0;
        repeat (65) tick();
        vectors++; if (board !== VERT) begin miscompares++; $display("FAIL pre_reset_board got %h want %h", board, VERT); end
        step = 1'b1; tick(); step = 1'b0;
        repeat (10) tick();
        #3 rst_n = 1'b0;
        #1;
        vectors++; if (board !== SEED_H) begin miscompares++; $display("FAIL async_reset_board got %h want %h", board, SEED_H); end
        vectors++; if (busy !== 1'b0 || gen_count !== 16'd0) begin miscompares++; $display("FAIL async_reset_state busy %b count %0d want 0 0", busy, gen_count); end
        #2 rst_n = 1'b1;
        tick();
        step = 1'b1; tick(); step = 1'b0;
        repeat (10) tick();
        step = 1'b1; tick(); step = 1'b0;
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL busy_mid_scan got %b want 1", busy); end
        repeat (70) tick();
        vectors++; if (gen_count !== 16'd1 || board !== VERT || busy !== 1'b0) begin miscompares++; $display("FAIL dropped_step count %0d board %h busy %b want 1 %h 0", gen_count, board, busy, VERT); end
    endtask

    initial begin
        clk = 1'b0; rst_n = 1'b0; frame_tick = 1'b0; run = 1'b0;
        step = 1'b0; clear = 1'b0; load = 1'b0; rd_addr = 6'd0;
        test_reset();
        test_step();
        test_run();
        test_lshape();
        test_clear();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
